// File: rtl/adiv5_arbiter_if.sv
// Requester-side and downstream-side signal bundle of the two-requester ADIv5 arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/debug-mux view.
interface adiv5_arbiter_if #(
    parameter int CMD_W  = 36,
    parameter int RESP_W = 35
);
    logic [CMD_W-1:0]  R0_WRDATA;
    logic              R0_LOCK;
    logic              R0_WREN;
    logic              R0_WRFULL;
    logic [RESP_W-1:0] R0_RDDATA;
    logic              R0_RDEN;
    logic              R0_RDEMPTY;

    logic [CMD_W-1:0]  R1_WRDATA;
    logic              R1_LOCK;
    logic              R1_WREN;
    logic              R1_WRFULL;
    logic [RESP_W-1:0] R1_RDDATA;
    logic              R1_RDEN;
    logic              R1_RDEMPTY;

    logic [CMD_W-1:0]  ADIv5_WRDATA;
    logic              ADIv5_WREN;
    logic              ADIv5_WRFULL;
    logic [RESP_W-1:0] ADIv5_RDDATA;
    logic              ADIv5_RDEN;
    logic              ADIv5_RDEMPTY;

    logic              STRAY;

    modport slave (
        input  R0_WRDATA, R0_LOCK, R0_WREN, R0_RDEN,
        output R0_WRFULL, R0_RDDATA, R0_RDEMPTY,
        input  R1_WRDATA, R1_LOCK, R1_WREN, R1_RDEN,
        output R1_WRFULL, R1_RDDATA, R1_RDEMPTY,
        output ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN,
        input  ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY,
        output STRAY
    );

    modport master (
        output R0_WRDATA, R0_LOCK, R0_WREN, R0_RDEN,
        input  R0_WRFULL, R0_RDDATA, R0_RDEMPTY,
        output R1_WRDATA, R1_LOCK, R1_WREN, R1_RDEN,
        input  R1_WRFULL, R1_RDDATA, R1_RDEMPTY,
        input  ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN,
        output ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY,
        input  STRAY
    );
endinterface

// File: rtl/adiv5_arbiter.sv
// Two-requester arbiter for one ADIv5 command/response FIFO port: round-robin issue with
// optional lock, and an in-order tag FIFO that steers each response back to its issuer.
module adiv5_arbiter #(
    parameter int CMD_W  = 36,
    parameter int RESP_W = 35,
    parameter int TAG_AW = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    adiv5_arbiter_if.slave bus
);
    localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW + 1)'(1 << TAG_AW);

    logic [CMD_W-1:0]      wr_data [2];
    logic [1:0]            wr_en;
    logic [1:0]            wr_lock;
    logic [1:0]            rd_en;

    logic [1:0]            slot_valid;
    logic [1:0]            slot_lock;
    logic [CMD_W-1:0]      slot_data [2];
    logic                  lock_valid;
    logic                  lock_owner;
    logic                  last_grant;

    logic [(1<<TAG_AW)-1:0] tag_mem;
    logic [TAG_AW-1:0]     tag_wr_ptr;
    logic [TAG_AW-1:0]     tag_rd_ptr;
    logic [TAG_AW:0]       tag_count;

    logic [1:0]            resp_valid;
    logic [RESP_W-1:0]     resp_data [2];
    logic                  stray_q;

    logic [1:0]            eligible;
    logic                  grant;
    logic                  issue;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_head;
    logic                  resp_pop;
    logic                  resp_drain;

    assign wr_data[0] = bus.R0_WRDATA;
    assign wr_data[1] = bus.R1_WRDATA;
    assign wr_en      = {bus.R1_WREN, bus.R0_WREN};
    assign wr_lock    = {bus.R1_LOCK, bus.R0_LOCK};
    assign rd_en      = {bus.R1_RDEN, bus.R0_RDEN};

    // Issue and response-pop decisions are combinational from registered state.
    always_comb begin
        eligible[0] = slot_valid[0] & (~lock_valid | ~lock_owner);
        eligible[1] = slot_valid[1] & (~lock_valid |  lock_owner);
        tag_full    = (tag_count == TAG_FULL);
        tag_empty   = (tag_count == '0);
        grant       = (&eligible) ? ~last_grant : eligible[1];
        issue       = ~RESET & (|eligible) & ~bus.ADIv5_WRFULL & ~tag_full;
        tag_head    = tag_mem[tag_rd_ptr];
        resp_pop    = ~RESET & ~bus.ADIv5_RDEMPTY & ~tag_empty &
                      (~resp_valid[tag_head] | rd_en[tag_head]);
        resp_drain  = ~RESET & ~bus.ADIv5_RDEMPTY & tag_empty;
    end

    assign bus.ADIv5_WREN   = issue;
    assign bus.ADIv5_WRDATA = issue ? slot_data[grant] : '0;
    assign bus.ADIv5_RDEN   = resp_pop | resp_drain;

    assign bus.R0_WRFULL  = slot_valid[0];
    assign bus.R1_WRFULL  = slot_valid[1];
    assign bus.R0_RDEMPTY = ~resp_valid[0];
    assign bus.R1_RDEMPTY = ~resp_valid[1];
    assign bus.R0_RDDATA  = resp_data[0];
    assign bus.R1_RDDATA  = resp_data[1];
    assign bus.STRAY      = stray_q;

    // A slot only captures while empty, so it never collides with its own issue-clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_valid   <= '0;
            slot_lock    <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
            lock_valid   <= 1'b0;
            lock_owner   <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (wr_en[n] && !slot_valid[n]) begin
                    slot_valid[n] <= 1'b1;
                    slot_lock[n]  <= wr_lock[n];
                    slot_data[n]  <= wr_data[n];
                end
            end
            if (issue) begin
                slot_valid[grant] <= 1'b0;
                last_grant        <= grant;
                lock_valid        <= slot_lock[grant];
                if (slot_lock[grant])
                    lock_owner <= grant;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tag_mem    <= '0;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (issue) begin
                tag_mem[tag_wr_ptr] <= grant;
                tag_wr_ptr          <= tag_wr_ptr + 1'b1;
            end
            if (resp_pop)
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            case ({issue, resp_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // A read and a refill of the same slot in one cycle leave it full with the new data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            resp_valid   <= '0;
            resp_data[0] <= '0;
            resp_data[1] <= '0;
            stray_q      <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (rd_en[n] && resp_valid[n])
                    resp_valid[n] <= 1'b0;
            end
            if (resp_pop) begin
                resp_valid[tag_head] <= 1'b1;
                resp_data[tag_head]  <= bus.ADIv5_RDDATA;
            end
            if (resp_drain)
                stray_q <= 1'b1;
        end
    end
endmodule
